pulse_scheduler: RTL

//  Timestamped command scheduler in front of one pulser channel. It queues 64-bit pulser

---
 rtl/pulse_scheduler_if.sv | 14 +
 rtl/pulse_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler_if.sv
// Command write port of the pulse scheduler: a timestamped pulser command
// offered with valid and accepted while the scheduler FIFO has room.
interface pulse_scheduler_if #(
  parameter int TW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_time;
  logic [63:0]   in_cmd;
  logic          in_zero;

  modport master (output in_valid, in_time, in_cmd, in_zero, input in_ready);
  modport slave  (input in_valid, in_time, in_cmd, in_zero, output in_ready);
endinterface

// File: rtl/pulse_scheduler.sv
// Timestamped command scheduler for one pulser channel. Commands wait in a
// FIFO, one at a time move into a hold register, and strobe into the pulser
// when the free-running timer reaches their start time. A strobe is never
// issued while the pulser is active or inside the post-strobe guard window.
// A command whose time has already passed counts as late, and is either
// issued at the first legal cycle or discarded, depending on DROP.
module pulse_scheduler #(
  parameter int AW    = 4,
  parameter int TW    = 32,
  parameter int DROP  = 0,
  parameter int GUARD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                tref,
  input  logic                flush,
  input  logic                pulser_active,
  pulse_scheduler_if.slave    cmd_in,
  output logic [63:0]         command,
  output logic                strobe,
  output logic                daczero,
  output logic [TW-1:0]       timer,
  output logic [AW:0]         level,
  output logic                late,
  output logic [15:0]         late_cnt
);

  localparam int DEPTH = 1 << AW;
  localparam int GW    = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  typedef struct packed {
    logic [TW-1:0] t;
    logic [63:0]   cmd;
    logic          zero;
  } entry_t;

  // EMPTY: hold register free; ARMED: hold register carries the next command.
  // The strobe cycle itself is the registered strobe output.
  typedef enum logic {EMPTY, ARMED} hold_state_e;

  entry_t        mem [DEPTH];
  entry_t        hold;
  hold_state_e   state;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [GW-1:0] guard;

  logic          wr_en;
  logic          pop;
  logic          fire;
  logic          issue;
  logic          due;
  logic          is_late;
  logic [TW-1:0] next_time;
  logic [TW-1:0] diff;

  // Occupancy from the extra pointer bit; full exactly when the MSB is set.
  assign level           = wr_ptr - rd_ptr;
  assign cmd_in.in_ready = ~level[AW];
  assign wr_en           = cmd_in.in_valid & cmd_in.in_ready & ~flush;

  // Wrap-safe due test against the time the strobe will actually appear.
  assign next_time = timer + 1'b1;
  assign diff      = hold.t - next_time;
  assign is_late   = diff[TW-1];
  assign due       = is_late | (diff == '0);

  assign fire  = run & ~tref & (state == ARMED) & due & ~pulser_active
               & (guard == '0) & ~flush;
  assign issue = fire & ((DROP == 0) | ~is_late);
  assign pop   = (level != '0) & ((state == EMPTY) | fire) & ~flush;

  // Timer: clear wins over count; frozen while run is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (tref) begin
      timer <= '0;
    end else if (run) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      timer <= next_time;
    end
  end

  // FIFO storage.
  // NOTE: the array has no reset; entries are only read after being written, and reset empties the FIFO through its pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= '{t: cmd_in.in_time, cmd: cmd_in.in_cmd, zero: cmd_in.in_zero};
    end
  end

  // FIFO pointers; flush discards all queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Hold register, issue/drop decision, guard window and late accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      hold     <= '0;
      strobe   <= 1'b0;
      command  <= '0;
      daczero  <= 1'b0;
      late     <= 1'b0;
      late_cnt <= '0;
      guard    <= '0;
    end else begin
      strobe <= 1'b0;
      late   <= 1'b0;
      if (guard != '0) guard <= guard - 1'b1;

      if (flush) begin
        state <= EMPTY;
      end else begin
        if (pop) begin
          hold  <= mem[rd_ptr[AW-1:0]];
          state <= ARMED;
        end else if (fire) begin
          state <= EMPTY;
        end

        if (issue) begin
          strobe  <= 1'b1;
          command <= hold.cmd;
          daczero <= hold.zero;
          guard   <= GUARD[GW-1:0];
        end

        if (fire && is_late) begin
          late <= 1'b1;
          if (late_cnt != 16'hFFFF) late_cnt <= late_cnt + 1'b1;
        end
      end
    end
  end

endmodule
